// File: rtl/t10_uart_pkg.sv
// Shared UART definitions: frame FSM states, default baud divisor and data width.
// Intended for reuse by a future t10 receiver.
package t10_uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 1042;
    localparam int unsigned DATA_WIDTH           = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/t10_baud_tick.sv
// Bit-period counter: one-cycle bit_tick on the last cycle of every bit period.
// The counter is held at zero while clear is asserted.
module t10_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic nRst,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_tick = (cnt == LAST);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt <= '0;
        end else if (clear || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/t10_uart_tx.sv
// UART transmitter: 8N1 frames, or 8-E-1 when T10_UART_TX_PARITY_EN is defined.
// One-cycle transmit_ready acknowledges each accepted byte.
module t10_uart_tx
    import t10_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  tx_ctrl,
    input  logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  transmit_ready,
    output logic                  tx_busy,
    output logic                  tx_serial
);

    tx_state_t             state, next_state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [2:0]            bit_idx;
    logic                  accept;
    logic                  bit_tick;
    logic                  line;
`ifdef T10_UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    // Counter is held cleared in IDLE, so every frame starts at count zero.
    t10_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .nRst     (nRst),
        .clear    (state == IDLE),
        .bit_tick (bit_tick)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        line       = 1'b1;
        case (state)
            IDLE: begin
                if (tx_ctrl) begin
                    accept     = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                line = 1'b0;
                if (bit_tick) next_state = DATA;
            end
            DATA: begin
                line = shift_reg[0];
                if (bit_tick && bit_idx == 3'd7) begin
`ifdef T10_UART_TX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef T10_UART_TX_PARITY_EN
            PARITY: begin
                line = parity_bit;
                if (bit_tick) next_state = STOP;
            end
`endif
            STOP: begin
                line = 1'b1;
                if (bit_tick) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state          <= IDLE;
            shift_reg      <= '0;
            bit_idx        <= '0;
            transmit_ready <= 1'b0;
        end else begin
            state          <= next_state;
            transmit_ready <= accept;
            if (accept) begin
                shift_reg <= tx_byte;
                bit_idx   <= '0;
            end else if (state == DATA && bit_tick) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

`ifdef T10_UART_TX_PARITY_EN
    // Even parity is captured at acceptance since the shift register is consumed.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= ^tx_byte;
        end
    end
`endif

    assign tx_serial = line;
    assign tx_busy   = (state != IDLE);

endmodule

// File: tb/tb_t10_uart_tx.sv
// Scoreboard bench for t10_uart_tx: driver queues expected bytes, a line
// monitor reconstructs frames and compares them against a bit-level model.
module tb_t10_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef T10_UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS = PAR ? 11 : 10;
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       tx_ctrl = 1'b0;
    logic [7:0] tx_byte = '0;
    logic       transmit_ready;
    logic       tx_busy;
    logic       tx_serial;

    t10_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .nRst           (nRst),
        .tx_ctrl        (tx_ctrl),
        .tx_byte        (tx_byte),
        .transmit_ready (transmit_ready),
        .tx_busy        (tx_busy),
        .tx_serial      (tx_serial)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [7:0] exp_q[$];
    int ack_count = 0;
    int stray_acks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference line waveform: start, 8 data LSB first, optional even parity, stop.
    function automatic logic [63:0] frame_model(input logic [7:0] b);
        logic [63:0] v;
        int k;
        v = '0;
        for (int t = 0; t < FRAME; t++) begin
            k = t / CPB;
            if (k == 0)                 v[t] = 1'b0;
            else if (k <= 8)            v[t] = ((b >> (k - 1)) & 8'd1) != 0;
            else if (PAR && k == 9)     v[t] = ($countones(b) % 2) == 1;
            else                        v[t] = 1'b1;
        end
        return v;
    endfunction

    // Monitor
    initial begin : monitor
        logic        in_frame;
        logic        gap_chk;
        logic        busy_ok;
        logic [63:0] act_v;
        logic [7:0]  eb;
        int          pos;
        int          acks_in;
        in_frame = 1'b0;
        gap_chk  = 1'b0;
        busy_ok  = 1'b1;
        act_v    = '0;
        pos      = 0;
        acks_in  = 0;
        forever begin
            @(negedge clk);
            if (transmit_ready) ack_count++;
            if (!nRst) begin
                if (in_frame && exp_q.size() > 0) void'(exp_q.pop_front());
                in_frame = 1'b0;
                gap_chk  = 1'b0;
            end else begin
                if (gap_chk) begin
                    gap_chk = 1'b0;
                    if (tx_serial) chk("idle_after_frame_busy", {63'd0, tx_busy}, 64'd0);
                end
                if (!in_frame && !tx_serial) begin
                    in_frame = 1'b1;
                    pos      = 0;
                    busy_ok  = 1'b1;
                    acks_in  = 0;
                    act_v    = '0;
                    chk("start_ack", {63'd0, transmit_ready}, 64'd1);
                    chk("start_busy", {63'd0, tx_busy}, 64'd1);
                end else if (!in_frame && transmit_ready) begin
                    stray_acks++;
                end
                if (in_frame) begin
                    act_v[pos] = tx_serial;
                    if (!tx_busy) busy_ok = 1'b0;
                    if (transmit_ready) acks_in++;
                    pos++;
                    if (pos == FRAME) begin
                        in_frame = 1'b0;
                        gap_chk  = 1'b1;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", act_v, 64'hFFFF_FFFF_FFFF_FFFF);
                        end else begin
                            eb = exp_q.pop_front();
                            chk("frame_bits", act_v, frame_model(eb));
                            chk("frame_busy", {63'd0, busy_ok}, 64'd1);
                            chk("frame_one_ack", 64'(acks_in), 64'd1);
                        end
                    end
                end
            end
        end
    end

    // Raise tx_ctrl with b, wait for the acknowledge, hold for `hold` more cycles,
    // and drive `after` onto tx_byte once acknowledged.
    task automatic send(input logic [7:0] b, input int hold, input logic [7:0] after);
        int n;
        @(negedge clk);
        tx_byte = b;
        tx_ctrl = 1'b1;
        exp_q.push_back(b);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!transmit_ready && n < 200);
        if (!transmit_ready) chk("ack_timeout", 64'd0, 64'd1);
        tx_byte = after;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        tx_ctrl = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("idle_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int n;
        int acks_before;
        logic [7:0] rb;
        // Reset state
        #12;
        chk("reset_serial", {63'd0, tx_serial}, 64'd1);
        chk("reset_busy", {63'd0, tx_busy}, 64'd0);
        chk("reset_ready", {63'd0, transmit_ready}, 64'd0);
        @(negedge clk); #2;
        nRst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_serial", {63'd0, tx_serial}, 64'd1);

        // Directed frames
        send(8'hA5, 0, 8'hA5); wait_idle();
        send(8'h07, 0, 8'h07); wait_idle();
        send(8'h03, 0, 8'h03); wait_idle();
        send(8'h5A, 1, 8'h5A); wait_idle();
        send(8'hC3, 0, 8'h3C); wait_idle();

        // Back-to-back with tx_ctrl held high throughout
        @(negedge clk);
        tx_byte = 8'h00;
        tx_ctrl = 1'b1;
        exp_q.push_back(8'h00);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!transmit_ready && n < 200);
        if (!transmit_ready) chk("b2b_ack1_timeout", 64'd0, 64'd1);
        tx_byte = 8'hFF;
        exp_q.push_back(8'hFF);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!transmit_ready && n < 200);
        chk("b2b_ack_gap", 64'(n), 64'(FRAME + 1));
        tx_ctrl = 1'b0;
        wait_idle();

        // Reset in the middle of the data bits
        send(8'h96, 0, 8'h96);
        repeat (3 * CPB) @(negedge clk);
        #2;
        nRst = 1'b0;
        #1;
        chk("rst_mid_serial", {63'd0, tx_serial}, 64'd1);
        chk("rst_mid_busy", {63'd0, tx_busy}, 64'd0);
        chk("rst_mid_ready", {63'd0, transmit_ready}, 64'd0);
        repeat (3) @(negedge clk);
        #2;
        nRst = 1'b1;
        acks_before = ack_count;
        repeat (20) @(negedge clk);
        chk("rst_no_ack", 64'(ack_count), 64'(acks_before));
        chk("rst_idle_busy", {63'd0, tx_busy}, 64'd0);

        // Randomized traffic, sometimes queued while a frame is in flight
        for (int i = 0; i < 16; i++) begin
            rb = 8'($urandom);
            send(rb, $urandom_range(0, 1), 8'($urandom));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        chk("stray_acks", 64'(stray_acks), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
